rat_path_buffer: RTL and testbench
==================================

RAT_PATH_BUFFER -- requirements
Module: rat_path_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 2, bits per path entry (move-direction code).
REQ-002 SHALL have parameter DEPTH, default 16, entry capacity; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of contents and error flags.
REQ-006 SHALL have port push  input  1  write din as new top entry.
REQ-007 SHALL have port pop  input  1  discard top entry (backtrack).
REQ-008 SHALL have port din  input  WIDTH  entry to push.
REQ-009 SHALL have port top  output  WIDTH  current top entry; 0 when empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-011 SHALL have ports empty, full  output  1 each  count==0, count==DEPTH.
REQ-012 SHALL have port replay_start  input  1  request in-order readout, oldest entry first.
REQ-013 SHALL have ports rep_valid  output  1, rep_ready  input  1, rep_data  output  WIDTH  replay handshake.
REQ-014 SHALL have port replay_done  output  1  one-cycle pulse when replay ends.
REQ-015 SHALL have port busy  output  1  high in REPLAY and DONE states.
REQ-016 SHALL have ports ovf, unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 SHALL implement states IDLE, REPLAY, DONE; count, read pointer rptr, entry array mem.
REQ-018 SHALL drive top = mem[count-1] combinationally when count>0, else 0.
REQ-019 In IDLE, push only, not full: mem[count]<=din, count+1 next cycle.
REQ-020 In IDLE, pop only, not empty: count-1 next cycle; stored data untouched.
REQ-021 In IDLE, push and pop, not empty: mem[count-1]<=din, count unchanged (replace top).
REQ-022 In IDLE, push and pop, empty: treated as push only.
REQ-023 Push only while full: no change to mem/count; ovf<=1.
REQ-024 Pop only while empty: no change; unf<=1.
REQ-025 ovf/unf SHALL stay set until clear or reset.
REQ-026 clear SHALL have priority over push, pop, replay_start: count<=0, ovf<=0, unf<=0, state<=IDLE, rptr<=0, no replay_done pulse.
REQ-027 In IDLE, replay_start with count>0: state<=REPLAY, rptr<=0; push/pop that same cycle ignored.
REQ-028 In IDLE, replay_start with count==0: state<=DONE directly.
REQ-029 In REPLAY: rep_valid=1, rep_data=mem[rptr]; rep_data held stable until accepted.
REQ-030 On rep_valid&rep_ready: if rptr==count-1, state<=DONE; else rptr+1.
REQ-031 In REPLAY and DONE, push/pop SHALL be ignored without setting ovf/unf; replay_start ignored outside IDLE.
REQ-032 In DONE: replay_done=1 for exactly one cycle, rep_valid=0, then IDLE; contents and count preserved.
REQ-033 rep_valid=0 and rep_data=0 outside REPLAY.

Reset
REQ-034 rst low SHALL immediately force state IDLE, count 0, rptr 0, ovf 0, unf 0, rep_valid 0, replay_done 0, busy 0, top 0, rep_data 0, empty 1, full 0; mem need not be reset.
REQ-035 rst asserted mid-replay SHALL abort without replay_done; operation resumes in IDLE on first edge after release.

Verification
REQ-036 Push 1,2,3 then pop -> count 2, top 2; pop, pop -> empty 1, top 0; extra pop -> unf 1, count 0.
REQ-037 DEPTH=16: push 16 entries -> full 1; 17th push -> ovf 1, count 16, top unchanged; clear -> count 0, ovf 0.
REQ-038 Push 3 then push+pop with din=1 while count 3 -> count 3, top 1; push+pop when empty with din=2 -> count 1, top 2.
REQ-039 Push 0,1,2,3, replay_start, rep_ready random -> rep_data sequence 0,1,2,3, each stable until accepted; replay_done one cycle after last accept; count 4, top 3; push during replay -> ignored.
REQ-040 replay_start with empty -> busy 1 one cycle, replay_done pulse next cycle, no rep_valid.
REQ-041 Assert rst low during REPLAY with rep_ready=0 -> all outputs reset same cycle, no replay_done; after release push 2 -> count 1, top 2.

Source files
------------

// File: rtl/rat_path_buffer.sv
// LIFO path store for maze backtracking, with an oldest-first replay port.
// Single-cycle update; replay advances one entry per rep_valid&rep_ready and holds rep_data until it is accepted.
module rat_path_buffer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  input  logic                       replay_start,
  output logic                       rep_valid,
  input  logic                       rep_ready,
  output logic [WIDTH-1:0]           rep_data,
  output logic                       replay_done,
  output logic                       busy,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPLAY = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [PW-1:0]    top_addr;
  logic             is_empty;
  logic             is_full;
  logic             last_entry;

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CW'(DEPTH));
  assign top_addr   = PW'(count_q - CW'(1));
  assign last_entry = (CW'(rptr_q) == (count_q - CW'(1)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = '0;

    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      rptr_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (replay_start) begin
            rptr_d  = '0;
            state_d = is_empty ? S_DONE : S_REPLAY;
          end else if (push && (!pop || is_empty)) begin
            if (is_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_addr = PW'(count_q);
              count_d = count_q + CW'(1);
            end
          end else if (push && pop) begin
            // Simultaneous push+pop on a non-empty stack overwrites the top in place.
            wr_en   = 1'b1;
            wr_addr = top_addr;
          end else if (pop) begin
            if (is_empty) begin
              unf_d = 1'b1;
            end else begin
              count_d = count_q - CW'(1);
            end
          end
        end
        S_REPLAY: begin
          if (rep_ready) begin
            if (last_entry) begin
              state_d = S_DONE;
            end else begin
              rptr_d = rptr_q + PW'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  assign top         = is_empty ? '0 : mem[top_addr];
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign rep_valid   = (state_q == S_REPLAY);
  assign rep_data    = (state_q == S_REPLAY) ? mem[rptr_q] : '0;
  assign replay_done = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign ovf         = ovf_q;
  assign unf         = unf_q;

endmodule

// File: tb/tb_rat_path_buffer.sv
// Directed self-checking bench for rat_path_buffer (WIDTH=2, DEPTH=16).
module tb_rat_path_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [1:0] din = 2'd0;
  logic [1:0] top;
  logic [4:0] count;
  logic       empty, full;
  logic       replay_start = 1'b0;
  logic       rep_valid;
  logic       rep_ready = 1'b0;
  logic [1:0] rep_data;
  logic       replay_done, busy, ovf, unf;

  int errors = 0;
  int checks = 0;

  rat_path_buffer #(.WIDTH(2), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .din(din),
    .top(top), .count(count), .empty(empty), .full(full),
    .replay_start(replay_start), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_data(rep_data), .replay_done(replay_done), .busy(busy),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [1:0] d);
    push = 1'b1; din = d;
    tick();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [7:0] rdy_pat;
    int k;
    int cyc;
    logic accepted;

    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_top", top, 0);
    check("rst_busy", busy, 0);
    check("rst_rep_valid", rep_valid, 0);
    check("rst_rep_data", rep_data, 0);
    check("rst_done", replay_done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Push/pop basics and underflow
    do_push(2'd1); do_push(2'd2); do_push(2'd3);
    check("p3_count", count, 3);
    check("p3_top", top, 3);
    do_pop();
    check("pop_count", count, 2);
    check("pop_top", top, 2);
    do_pop(); do_pop();
    check("drain_empty", empty, 1);
    check("drain_top", top, 0);
    check("drain_unf", unf, 0);
    do_pop();
    check("unf_set", unf, 1);
    check("unf_count", count, 0);
    tick();
    check("unf_sticky", unf, 1);
    do_clear();
    check("clr_unf", unf, 0);

    // Fill to capacity and overflow
    for (int i = 0; i < 16; i++) do_push(2'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_top", top, 3);
    do_push(2'd0);
    check("ovf_set", ovf, 1);
    check("ovf_count", count, 16);
    check("ovf_top", top, 3);
    do_clear();
    check("clr_count", count, 0);
    check("clr_ovf", ovf, 0);
    check("clr_empty", empty, 1);

    // Replace-top and push+pop when empty
    do_push(2'd2); do_push(2'd3); do_push(2'd0);
    push = 1'b1; pop = 1'b1; din = 2'd1;
    tick();
    push = 1'b0; pop = 1'b0;
    check("rep_top_count", count, 3);
    check("rep_top_top", top, 1);
    do_pop();
    check("rep_top_below", top, 3);
    do_clear();
    push = 1'b1; pop = 1'b1; din = 2'd2;
    tick();
    push = 1'b0; pop = 1'b0;
    check("pp_empty_count", count, 1);
    check("pp_empty_top", top, 2);
    check("pp_empty_unf", unf, 0);
    do_clear();

    // Replay with irregular rep_ready, push/pop attempts ignored
    do_push(2'd0); do_push(2'd1); do_push(2'd2); do_push(2'd3);
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    check("rp_busy", busy, 1);
    rdy_pat = 8'b1011_0010;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      rep_ready = rdy_pat[cyc % 8];
      push = 1'b1; din = 2'd1; pop = cyc[0];
      check("rp_valid", rep_valid, 1);
      check("rp_data", rep_data, k);
      check("rp_no_done", replay_done, 0);
      accepted = rep_ready;
      tick();
      if (accepted) k++;
      cyc++;
    end
    check("rp_accepts", k, 4);
    rep_ready = 1'b0; push = 1'b0; pop = 1'b0;
    check("rp_done", replay_done, 1);
    check("rp_done_valid", rep_valid, 0);
    check("rp_done_data", rep_data, 0);
    check("rp_done_busy", busy, 1);
    tick();
    check("rp_done_pulse", replay_done, 0);
    check("rp_idle_busy", busy, 0);
    check("rp_count", count, 4);
    check("rp_top", top, 3);
    check("rp_ovf", ovf, 0);
    check("rp_unf", unf, 0);
    do_clear();

    // Replay on empty buffer
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    check("er_busy", busy, 1);
    check("er_done", replay_done, 1);
    check("er_valid", rep_valid, 0);
    tick();
    check("er_busy_off", busy, 0);
    check("er_done_off", replay_done, 0);

    // Async reset mid-replay
    do_push(2'd1); do_push(2'd2);
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    rep_ready = 1'b0;
    check("ar_valid_pre", rep_valid, 1);
    check("ar_data_pre", rep_data, 1);
    rst = 1'b0;
    #1;
    check("ar_valid", rep_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_count", count, 0);
    check("ar_top", top, 0);
    check("ar_data", rep_data, 0);
    check("ar_empty", empty, 1);
    tick();
    check("ar_no_done", replay_done, 0);
    rst = 1'b1;
    do_push(2'd2);
    check("ar_post_count", count, 1);
    check("ar_post_top", top, 2);
    check("ar_post_done", replay_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
